packet_sink: RTL and testbench

- Receive-side counterpart of the NoC packet generator/injector.
- Attaches to one network exit gate (router output port on the mesh boundary) and accepts 5-flit packets through a credit-flow link.
- Buffers, reassembles and checks each packet, then reports per-packet header fields and running counts.
- Used in network validation and performance benches; fully synthesizable.

---
 rtl/packet_sink.sv | 150 +++++++++++++++
 tb/tb_packet_sink.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_sink.sv
// ---------------------------------------------------------------------------
// packet_sink
//   Receive end of a NoC credit-flow link. It takes 5-flit packets (header +
//   four data flits) from one mesh exit gate, buffers them in a small FIFO,
//   reassembles them and reports each finished packet plus running counters.
//
// Ports
//   clk                in   system clock, rising edge
//   reset              in   synchronous, active-high reset
//   channel_din        in   incoming flit
//   flit_valid_din     in   channel_din carries a flit this cycle
//   credit_out         out  one-cycle pulse per flit popped from the FIFO
//   stall_din          in   hold off FIFO pops while high
//   packet_valid_dout  out  one-cycle pulse, packet complete
//   header_dout        out  header of the last completed packet
//   data_dout          out  {DATA_0, DATA_1, DATA_2, DATA_3} of that packet
//   gate_err_dout      out  header gate field differs from this gate (with valid)
//   head_err_dout      out  sticky, a non-header flit arrived while idle
//   overflow_err_dout  out  sticky, a flit arrived while the FIFO was full
//   pkt_count_dout     out  completed packets, wrapping
//   err_count_dout     out  packets with a gate error, saturating
// ---------------------------------------------------------------------------
module packet_sink #(
    parameter int CHANNEL_WIDTH = 32,
    parameter int BUFFER_DEPTH  = 4,
    parameter int X_GATE        = 0,
    parameter int Y_GATE        = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CHANNEL_WIDTH-1:0]   channel_din,
    input  logic                       flit_valid_din,
    output logic                       credit_out,
    input  logic                       stall_din,
    output logic                       packet_valid_dout,
    output logic [CHANNEL_WIDTH-1:0]   header_dout,
    output logic [4*CHANNEL_WIDTH-1:0] data_dout,
    output logic                       gate_err_dout,
    output logic                       head_err_dout,
    output logic                       overflow_err_dout,
    output logic [15:0]                pkt_count_dout,
    output logic [7:0]                 err_count_dout
);

    localparam int         AW   = $clog2(BUFFER_DEPTH);
    localparam logic [5:0] GATE = {3'(X_GATE), 3'(Y_GATE)};

    typedef enum logic [2:0] {S_IDLE, S_D0, S_D1, S_D2, S_D3, S_DONE} state_t;

    // ---------------- input FIFO ----------------
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [CHANNEL_WIDTH-1:0] r_mem [BUFFER_DEPTH];
    logic [AW:0]              r_wptr, r_rptr;
    logic                     w_empty, w_full, w_pop, w_push;
    logic [CHANNEL_WIDTH-1:0] w_flit;

    state_t r_state, w_state_nxt;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = !w_empty && !stall_din && (r_state != S_DONE);
    // A pop in the same cycle frees a slot, so a write into a full FIFO is fine then.
    assign w_push  = flit_valid_din && (!w_full || w_pop);
    assign w_flit  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= channel_din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr            <= '0;
            r_rptr            <= '0;
            credit_out        <= 1'b0;
            overflow_err_dout <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            credit_out <= w_pop;
            if (flit_valid_din && w_full && !w_pop) overflow_err_dout <= 1'b1;
        end
    end

    // ---------------- reassembly FSM ----------------
    logic w_latch_hdr, w_head_bad;

    always_comb begin
        w_state_nxt       = r_state;
        w_latch_hdr       = 1'b0;
        w_head_bad        = 1'b0;
        packet_valid_dout = 1'b0;
        gate_err_dout     = 1'b0;
        case (r_state)
            S_IDLE: if (w_pop) begin
                if (w_flit[31]) begin
                    w_latch_hdr = 1'b1;
                    w_state_nxt = S_D0;
                end else begin
                    w_head_bad  = 1'b1;   // stray flit: dropped, credit still returned
                end
            end
            S_D0:   if (w_pop) w_state_nxt = S_D1;
            S_D1:   if (w_pop) w_state_nxt = S_D2;
            S_D2:   if (w_pop) w_state_nxt = S_D3;
            S_D3:   if (w_pop) w_state_nxt = S_DONE;
            S_DONE: begin
                packet_valid_dout = 1'b1;
                gate_err_dout     = (header_dout[23:18] != GATE);
                w_state_nxt       = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Working latches for the packet in flight; the outputs are loaded on the
    // final pop so they are already valid during the DONE cycle and then hold.
    logic [CHANNEL_WIDTH-1:0] r_hdr, r_d0, r_d1, r_d2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_hdr          <= '0;
            r_d0           <= '0;
            r_d1           <= '0;
            r_d2           <= '0;
            header_dout    <= '0;
            data_dout      <= '0;
            head_err_dout  <= 1'b0;
            pkt_count_dout <= '0;
            err_count_dout <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch_hdr) r_hdr <= w_flit;
            if (w_head_bad)  head_err_dout <= 1'b1;
            if (w_pop && r_state == S_D0) r_d0 <= w_flit;
            if (w_pop && r_state == S_D1) r_d1 <= w_flit;
            if (w_pop && r_state == S_D2) r_d2 <= w_flit;
            if (w_pop && r_state == S_D3) begin
                header_dout <= r_hdr;
                data_dout   <= {r_d0, r_d1, r_d2, w_flit};
            end
            if (r_state == S_DONE) begin
                pkt_count_dout <= pkt_count_dout + 16'd1;
                if (gate_err_dout && err_count_dout != 8'hFF)
                    err_count_dout <= err_count_dout + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_packet_sink.sv
// Directed bench for packet_sink: a table of packets applied back to back,
// then hand-written sequences for stray flits, overflow under stall, counter
// saturation over a long stream, and reset in the middle of a packet.
module tb_packet_sink;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  channel_din;
    logic         flit_valid_din;
    logic         credit_out;
    logic         stall_din;
    logic         packet_valid_dout;
    logic [31:0]  header_dout;
    logic [127:0] data_dout;
    logic         gate_err_dout;
    logic         head_err_dout;
    logic         overflow_err_dout;
    logic [15:0]  pkt_count_dout;
    logic [7:0]   err_count_dout;

    packet_sink #(.CHANNEL_WIDTH(32), .BUFFER_DEPTH(4), .X_GATE(0), .Y_GATE(1)) dut (
        .clk(clk), .reset(reset), .channel_din(channel_din), .flit_valid_din(flit_valid_din),
        .credit_out(credit_out), .stall_din(stall_din), .packet_valid_dout(packet_valid_dout),
        .header_dout(header_dout), .data_dout(data_dout), .gate_err_dout(gate_err_dout),
        .head_err_dout(head_err_dout), .overflow_err_dout(overflow_err_dout),
        .pkt_count_dout(pkt_count_dout), .err_count_dout(err_count_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- monitor (samples on the falling edge) ----------------
    int           n_credit = 0, n_valid = 0, n_gerr_stray = 0;
    logic [31:0]  v_hdr;
    logic [127:0] v_data;
    logic         v_gerr;
    int           v_cyc;
    int           vq[$];
    logic [31:0]  hq[$];

    always @(negedge clk) begin
        if (reset) begin
            n_credit = 0;
            n_valid  = 0;
            vq.delete();
            hq.delete();
        end else begin
            if (credit_out) n_credit++;
            if (packet_valid_dout) begin
                n_valid++;
                v_hdr  = header_dout;
                v_data = data_dout;
                v_gerr = gate_err_dout;
                v_cyc  = cyc;
                vq.push_back(cyc);
                hq.push_back(header_dout);
            end else if (gate_err_dout) begin
                n_gerr_stray++;
            end
        end
    end

    // ---------------- credit-respecting driver ----------------
    int          sent = 0;
    int          last_t;
    logic [31:0] txq[$];

    task automatic stream();
        int idx = 0;
        int guard = 0;
        while (idx < txq.size()) begin
            @(negedge clk); #1;
            if (4 - sent + n_credit > 0) begin
                flit_valid_din = 1'b1;
                channel_din    = txq[idx];
                idx++;
                sent++;
                last_t = cyc;
            end else begin
                flit_valid_din = 1'b0;
            end
            guard++;
            if (guard > 20000) begin
                chk("stream_timeout", 128'(guard), 128'(0));
                break;
            end
        end
        @(negedge clk); #1;
        flit_valid_din = 1'b0;
    endtask

    task automatic wait_valid(input int target, input int budget);
        int k = 0;
        while (n_valid < target && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk("wait_valid", 128'(n_valid), 128'(target));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        flit_valid_din = 1'b0;
        stall_din      = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        sent  = 0;
    endtask

    // ---------------- packet table ----------------
    typedef struct {
        logic [31:0] hdr;
        logic [31:0] d0, d1, d2, d3;
        logic        gerr;
        int          pkt;
        int          err;
    } vec_t;
    vec_t tbl[4];

    task automatic load_pkt(input int r);
        txq.delete();
        txq.push_back(tbl[r].hdr);
        txq.push_back(tbl[r].d0);
        txq.push_back(tbl[r].d1);
        txq.push_back(tbl[r].d2);
        txq.push_back(tbl[r].d3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, c0, bad;
        reset = 1'b1; flit_valid_din = 1'b0; channel_din = '0; stall_din = 1'b0;

        // gate of this sink is {x0,y1} -> header[23:18] = 6'b000001
        tbl[0] = '{32'h8006_1005, "x+  ", "x =0", "y =6", "NTST", 1'b0, 1, 0};
        tbl[1] = '{32'h806A_1006, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 1'b1, 2, 1};
        tbl[2] = '{32'hC006_0FFF, 32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hA5A5_5A5A, 1'b0, 3, 1};
        tbl[3] = '{32'hBFFF_FABC, 32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_3210, 1'b1, 4, 2};

        do_reset();
        chk("rst_valid",    128'(packet_valid_dout), 128'(0));
        chk("rst_credit",   128'(credit_out),        128'(0));
        chk("rst_header",   128'(header_dout),       128'(0));
        chk("rst_data",     data_dout,               128'(0));
        chk("rst_errs",     128'({gate_err_dout, head_err_dout, overflow_err_dout}), 128'(0));
        chk("rst_counts",   128'({pkt_count_dout, err_count_dout}), 128'(0));

        // ---- table-driven packets, no stall ----
        for (int r = 0; r < 4; r++) begin
            load_pkt(r);
            v0 = n_valid;
            c0 = n_credit;
            stream();
            wait_valid(v0 + 1, 20);
            idle(3);
            chk($sformatf("t%0d_once", r),    128'(n_valid),        128'(v0 + 1));
            chk($sformatf("t%0d_latency", r), 128'(v_cyc - last_t), 128'(2));
            chk($sformatf("t%0d_header", r),  128'(v_hdr),          128'(tbl[r].hdr));
            chk($sformatf("t%0d_data", r),    v_data, {tbl[r].d0, tbl[r].d1, tbl[r].d2, tbl[r].d3});
            chk($sformatf("t%0d_gate_err", r), 128'(v_gerr),        128'(tbl[r].gerr));
            chk($sformatf("t%0d_pkt_cnt", r), 128'(pkt_count_dout), 128'(tbl[r].pkt));
            chk($sformatf("t%0d_err_cnt", r), 128'(err_count_dout), 128'(tbl[r].err));
            chk($sformatf("t%0d_credits", r), 128'(n_credit - c0),  128'(5));
            chk($sformatf("t%0d_hold", r),    128'(header_dout),    128'(tbl[r].hdr));
        end

        // ---- stray data flit in IDLE, then a good packet ----
        do_reset();
        txq.delete();
        txq.push_back(32'h1234_5678);
        stream();
        idle(4);
        chk("stray_head_err", 128'(head_err_dout), 128'(1));
        chk("stray_credit",   128'(n_credit),      128'(1));
        chk("stray_no_valid", 128'(n_valid),       128'(0));
        load_pkt(0);
        stream();
        wait_valid(1, 20);
        idle(3);
        chk("stray_pkt_cnt",  128'(pkt_count_dout), 128'(1));
        chk("stray_header",   128'(v_hdr),          128'(tbl[0].hdr));
        chk("stray_sticky",   128'(head_err_dout),  128'(1));
        chk("stray_credits",  128'(n_credit),       128'(6));

        // ---- overflow under stall ----
        do_reset();
        stall_din = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (i == 4) chk("ovf_not_yet", 128'(overflow_err_dout), 128'(0));
            flit_valid_din = 1'b1;
            channel_din    = (i == 0) ? tbl[0].hdr : 32'h5000_0000 + 32'(i);
        end
        @(negedge clk); #1;
        flit_valid_din = 1'b0;
        chk("ovf_set", 128'(overflow_err_dout), 128'(1));
        idle(3);
        chk("ovf_no_credit_stalled", 128'(n_credit), 128'(0));
        stall_din = 1'b0;
        idle(10);
        chk("ovf_credits_after",  128'(n_credit),          128'(4));
        chk("ovf_no_valid",       128'(n_valid),           128'(0));
        chk("ovf_sticky",         128'(overflow_err_dout), 128'(1));

        // ---- 300 back-to-back packets, all with a bad gate ----
        do_reset();
        txq.delete();
        for (int p = 0; p < 300; p++) begin
            txq.push_back(32'h806A_0000 | 32'(p));
            for (int d = 0; d < 4; d++) txq.push_back(32'(p * 4 + d));
        end
        stream();
        wait_valid(300, 100);
        idle(3);
        chk("long_pkt_cnt", 128'(pkt_count_dout), 128'(300));
        chk("long_err_sat", 128'(err_count_dout), 128'(255));
        chk("long_n_valid", 128'(vq.size()),      128'(300));
        bad = 0;
        for (int i = 1; i < vq.size(); i++) if (vq[i] - vq[i-1] != 6) bad++;
        chk("long_interval6", 128'(bad), 128'(0));
        bad = 0;
        for (int i = 0; i < hq.size(); i++) if (hq[i][11:0] != 12'(i)) bad++;
        chk("long_serials", 128'(bad), 128'(0));

        // ---- reset after D1, then a fresh packet ----
        do_reset();
        txq.delete();
        txq.push_back(tbl[0].hdr);
        txq.push_back(tbl[0].d0);
        txq.push_back(tbl[0].d1);
        stream();
        idle(3);
        do_reset();
        idle(8);
        chk("abort_no_valid", 128'(n_valid),        128'(0));
        chk("abort_pkt_cnt",  128'(pkt_count_dout), 128'(0));
        chk("abort_err_cnt",  128'(err_count_dout), 128'(0));
        load_pkt(1);
        stream();
        wait_valid(1, 20);
        idle(3);
        chk("abort_new_header", 128'(v_hdr), 128'(tbl[1].hdr));
        chk("abort_new_data",   v_data, {tbl[1].d0, tbl[1].d1, tbl[1].d2, tbl[1].d3});
        chk("abort_new_gerr",   128'(v_gerr),         128'(1));
        chk("abort_new_counts", 128'({pkt_count_dout, err_count_dout}), 128'({16'd1, 8'd1}));
        chk("abort_new_credits", 128'(n_credit),      128'(5));

        chk("gate_err_unqualified", 128'(n_gerr_stray), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
